// File: rtl/dht_timing_pkg.sv
// -----------------------------------------------------------------------------
// dht_timing_pkg
// Shared timing definitions for both ends of the singer_bus link (this
// responder and the FPGA sensor reader), so both agree on every phase length.
// Contents:
//   dht_state_e  - responder state encoding
//   ns2cyc()     - converts a delay in ns to clock cycles: (ns / period) + 1
//   DHT_*        - default clock period, frame length and phase delays
// -----------------------------------------------------------------------------
package dht_timing_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOST_LOW  = 4'd1,
        ST_RESP_WAIT = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_END_LOW   = 4'd7
    } dht_state_e;

    localparam int unsigned DHT_CLK_PERIOD_NS = 32'd83;      // 12 MHz
    localparam int unsigned DHT_N             = 32'd40;
    localparam int unsigned DHT_START_MIN_NS  = 32'd500000;
    localparam int unsigned DHT_RESP_WAIT_NS  = 32'd30000;
    localparam int unsigned DHT_RESP_NS       = 32'd80000;
    localparam int unsigned DHT_BIT_LOW_NS    = 32'd50000;
    localparam int unsigned DHT_BIT0_HIGH_NS  = 32'd26000;
    localparam int unsigned DHT_BIT1_HIGH_NS  = 32'd70000;

    // Collision watch opens on this cycle of a released phase (pull-up rise
    // plus synchronizer lag) and fires after this many consecutive lows.
    localparam int unsigned DHT_COLL_START_CYC = 32'd8;
    localparam int unsigned DHT_COLL_RUN_CYC   = 32'd4;

    // Level of the released (pulled-up) line.
    localparam logic DHT_BUS_IDLE = 1'b1;

    function automatic int unsigned ns2cyc(input int unsigned ns, input int unsigned period);
        return (ns / period) + 32'd1;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// -----------------------------------------------------------------------------
// bus_sync
// Two-flop synchronizer for the open-drain singer_bus line plus one-cycle
// rise/fall strobes derived from the synchronized level.
// Ports:
//   clk, rst (async, active-high)
//   bus_in  - raw line level
//   bus_s   - synchronized level
//   rise    - one-cycle strobe on a 0->1 transition of bus_s
//   fall    - one-cycle strobe on a 1->0 transition of bus_s
// -----------------------------------------------------------------------------
module bus_sync
    import dht_timing_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bus_in,
    output logic bus_s,
    output logic rise,
    output logic fall
);

    // [0] first sync stage, [1] second sync stage, [2] previous bus_s
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Next-state shift of the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[1:0], bus_in};
    end

    // Chain registers; reset to the released level so reset never looks like a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {3{DHT_BUS_IDLE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign bus_s = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/dht_sensor_responder.sv
// -----------------------------------------------------------------------------
// dht_sensor_responder
// Slave end of the single-wire singer_bus sensor protocol. Detects a host start
// pulse, answers with the low/high presence handshake, then sends an N-bit
// frame MSB-first with pulse-width encoding. Open-drain: only drives 0 or Z.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   singer_bus  - open-drain sensor line
//   data_in     - frame to send (captured once at start acceptance)
//   busy        - high from start acceptance until the bus is released
//   done        - one-cycle pulse when a frame completes
//   err         - one-cycle pulse on collision abort
//   bit_cnt     - bits sent in the current frame
// -----------------------------------------------------------------------------
module dht_sensor_responder
    import dht_timing_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = DHT_CLK_PERIOD_NS,
    parameter int unsigned N             = DHT_N,
    parameter int unsigned START_MIN_NS  = DHT_START_MIN_NS,
    parameter int unsigned RESP_WAIT_NS  = DHT_RESP_WAIT_NS,
    parameter int unsigned RESP_NS       = DHT_RESP_NS,
    parameter int unsigned BIT_LOW_NS    = DHT_BIT_LOW_NS,
    parameter int unsigned BIT0_HIGH_NS  = DHT_BIT0_HIGH_NS,
    parameter int unsigned BIT1_HIGH_NS  = DHT_BIT1_HIGH_NS
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire          singer_bus,
    input  logic [N-1:0] data_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [5:0]   bit_cnt
);

    // Down-counter load values are cycles-1 so a phase of C cycles ends on the
    // cycle the counter reads 0.
    localparam logic [15:0] START_MIN_CYC = 16'(ns2cyc(START_MIN_NS, CLK_PERIOD_NS));
    localparam logic [15:0] RESP_WAIT_LD  = 16'(ns2cyc(RESP_WAIT_NS, CLK_PERIOD_NS) - 32'd1);
    localparam logic [15:0] RESP_LD       = 16'(ns2cyc(RESP_NS, CLK_PERIOD_NS) - 32'd1);
    localparam logic [15:0] BIT_LOW_LD    = 16'(ns2cyc(BIT_LOW_NS, CLK_PERIOD_NS) - 32'd1);
    localparam logic [15:0] BIT0_LD       = 16'(ns2cyc(BIT0_HIGH_NS, CLK_PERIOD_NS) - 32'd1);
    localparam logic [15:0] BIT1_LD       = 16'(ns2cyc(BIT1_HIGH_NS, CLK_PERIOD_NS) - 32'd1);
    localparam logic [2:0]  COLL_AGE      = 3'(DHT_COLL_START_CYC - 32'd1);
    localparam logic [2:0]  COLL_LAST     = 3'(DHT_COLL_RUN_CYC - 32'd1);
    localparam logic [5:0]  N_BITS        = 6'(N);

    logic bus_s;
    logic rise_s;
    logic fall_s;
    logic coll_s;

    dht_state_e   state_q,   state_d;
    logic [15:0]  cnt_q,     cnt_d;
    logic [N-1:0] shreg_q,   shreg_d;
    logic [5:0]   bit_cnt_q, bit_cnt_d;
    logic         oe_q,      oe_d;
    logic         busy_q,    busy_d;
    logic         done_q,    done_d;
    logic         err_q,     err_d;
    logic [2:0]   age_q,     age_d;      // cycles elapsed in a released phase, saturating
    logic [2:0]   low_run_q, low_run_d;  // consecutive low samples inside the watch window

    bus_sync u_bus_sync (
        .clk    (clk),
        .rst    (rst),
        .bus_in (singer_bus),
        .bus_s  (bus_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // Next-state, counter, shift register and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        age_d     = 3'd0;
        low_run_d = 3'd0;
        coll_s    = 1'b0;

        // Collision watch: only in released phases, and only once the line has
        // had time to rise after our own low drive.
        if ((state_q == ST_RESP_HIGH) || (state_q == ST_BIT_HIGH)) begin
            if (age_q == COLL_AGE) begin
                age_d = age_q;
                if (bus_s == 1'b1) begin
                    low_run_d = 3'd0;
                end else if (fall_s == 1'b1) begin
                    low_run_d = 3'd1;
                end else begin
                    low_run_d = low_run_q + 3'd1;
                end
                coll_s = (bus_s == 1'b0) && (low_run_q == COLL_LAST);
            end else begin
                age_d     = age_q + 3'd1;
                low_run_d = 3'd0;
            end
        end else begin
            age_d     = 3'd0;
            low_run_d = 3'd0;
        end

        case (state_q)
            ST_IDLE: begin
                oe_d = 1'b0;
                if (bus_s == 1'b0) begin
                    state_d = ST_HOST_LOW;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST_LOW: begin
                // Inside HOST_LOW the line was low last cycle, so a high level is a rise.
                if (rise_s == 1'b1) begin
                    if (cnt_q >= START_MIN_CYC) begin
                        shreg_d   = data_in;
                        busy_d    = 1'b1;
                        bit_cnt_d = 6'd0;
                        cnt_d     = RESP_WAIT_LD;
                        state_d   = ST_RESP_WAIT;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RESP_WAIT: begin
                if (cnt_q == 16'd0) begin
                    oe_d    = 1'b1;
                    cnt_d   = RESP_LD;
                    state_d = ST_RESP_LOW;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RESP_LOW: begin
                if (cnt_q == 16'd0) begin
                    oe_d    = 1'b0;
                    cnt_d   = RESP_LD;
                    state_d = ST_RESP_HIGH;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RESP_HIGH: begin
                if (coll_s == 1'b1) begin
                    oe_d    = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    oe_d    = 1'b1;
                    cnt_d   = BIT_LOW_LD;
                    state_d = ST_BIT_LOW;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_BIT_LOW: begin
                if (cnt_q == 16'd0) begin
                    oe_d    = 1'b0;
                    cnt_d   = shreg_q[N-1] ? BIT1_LD : BIT0_LD;
                    state_d = ST_BIT_HIGH;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_BIT_HIGH: begin
                if (coll_s == 1'b1) begin
                    oe_d    = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    shreg_d   = {shreg_q[N-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    oe_d      = 1'b1;
                    cnt_d     = BIT_LOW_LD;
                    // The closing low has the same width as a bit preamble.
                    if ((bit_cnt_q + 6'd1) == N_BITS) begin
                        state_d = ST_END_LOW;
                    end else begin
                        state_d = ST_BIT_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_END_LOW: begin
                if (cnt_q == 16'd0) begin
                    oe_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            shreg_q   <= '0;
            bit_cnt_q <= 6'd0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            age_q     <= 3'd0;
            low_run_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            age_q     <= age_d;
            low_run_q <= low_run_d;
        end
    end

    assign singer_bus = oe_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_dht_sensor_responder.sv
// -----------------------------------------------------------------------------
// tb_dht_sensor_responder
// Directed bench for dht_sensor_responder with shortened phase delays. The
// bench plays the host/reader: it pulls the line low for a start, then decodes
// the responder's pulse widths back into a frame and compares it against the
// value queued when the start was issued.
// -----------------------------------------------------------------------------
module tb_dht_sensor_responder;

    localparam int P            = 83;
    localparam int NB           = 40;
    localparam int START_MIN_NS = 8300;
    localparam int RESP_WAIT_NS = 830;
    localparam int RESP_NS      = 3320;
    localparam int BIT_LOW_NS   = 1660;
    localparam int BIT0_NS      = 2490;
    localparam int BIT1_NS      = 4980;

    localparam int START_C = START_MIN_NS / P + 1;   // 101
    localparam int WAIT_C  = RESP_WAIT_NS / P + 1;   // 11
    localparam int RESP_C  = RESP_NS / P + 1;        // 41
    localparam int BLOW_C  = BIT_LOW_NS / P + 1;     // 21
    localparam int BIT0_C  = BIT0_NS / P + 1;        // 31
    localparam int BIT1_C  = BIT1_NS / P + 1;        // 61
    localparam int BOUND   = 5000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_low = 1'b0;
    logic [NB-1:0] data_in = '0;
    logic          busy, done, err;
    logic [5:0]    bit_cnt;
    wire           singer_bus;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [NB-1:0] exp_q[$];

    pullup (singer_bus);
    assign singer_bus = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht_sensor_responder #(
        .CLK_PERIOD_NS (P),
        .N             (NB),
        .START_MIN_NS  (START_MIN_NS),
        .RESP_WAIT_NS  (RESP_WAIT_NS),
        .RESP_NS       (RESP_NS),
        .BIT_LOW_NS    (BIT_LOW_NS),
        .BIT0_HIGH_NS  (BIT0_NS),
        .BIT1_HIGH_NS  (BIT1_NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .singer_bus (singer_bus),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bit_cnt    (bit_cnt)
    );

    // Pulse counters for done/err.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance at least one negedge, then until the line equals lvl.
    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (singer_bus !== lvl && n < BOUND);
    endtask

    // Count negedge samples at level lvl, starting with the current one.
    task automatic run_len(input logic lvl, input int bound, output int len);
        len = 0;
        while (singer_bus === lvl && len < bound) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_bitcnt(input logic [5:0] v, input string tag);
        int n = 0;
        while (bit_cnt !== v && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".reach_bitcnt"}, 64'(bit_cnt === v), 64'd1);
    endtask

    // Host start pulse of 'low' cycles; busy must stay low while the host holds.
    task automatic host_start(input int low, input string tag);
        @(negedge clk);
        host_low = 1'b1;
        tick(low);
        check({tag, ".busy_during_host_low"}, 64'(busy), 64'd0);
        host_low = 1'b0;
    endtask

    task automatic send(input logic [NB-1:0] d, input string tag);
        data_in = d;
        exp_q.push_back(d);
        host_start(3 * START_C, tag);
    endtask

    // Decode one frame from the release negedge onward and score it.
    task automatic rx_frame(input string tag, input logic do_change, input logic [NB-1:0] new_d);
        logic [NB-1:0] exp_w;
        logic [NB-1:0] got_w;
        int n;
        int d0;
        int e0;
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
            return;
        end
        exp_w = exp_q.pop_front();
        got_w = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        wait_level(1'b0, n);
        check({tag, ".latency"}, 64'(n), 64'(3 + WAIT_C));
        check({tag, ".busy"}, 64'(busy), 64'd1);
        if (do_change) data_in = new_d;
        run_len(1'b0, BOUND, n);
        check({tag, ".resp_low"}, 64'(n), 64'(RESP_C));
        run_len(1'b1, BOUND, n);
        check({tag, ".resp_high"}, 64'(n), 64'(RESP_C));
        for (int i = 0; i < NB; i++) begin
            run_len(1'b0, BOUND, n);
            check($sformatf("%s.b%0d_low", tag, i), 64'(n), 64'(BLOW_C));
            run_len(1'b1, BOUND, n);
            check($sformatf("%s.b%0d_high", tag, i), 64'(n),
                  64'(exp_w[NB-1-i] ? BIT1_C : BIT0_C));
            got_w = {got_w[NB-2:0], (n == BIT1_C)};
        end
        run_len(1'b0, BOUND, n);
        check({tag, ".end_low"}, 64'(n), 64'(BLOW_C));
        check({tag, ".done_at_release"}, 64'(done), 64'd1);
        check({tag, ".busy_at_release"}, 64'(busy), 64'd0);
        tick(2);
        check({tag, ".done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, ".err_pulses"}, 64'(err_cnt - e0), 64'd0);
        check({tag, ".frame"}, 64'(got_w), 64'(exp_w));
    endtask

    initial begin
        int n;
        int d0;
        int e0;
        int err_at;
        int low_hits;
        int busy_hits;

        // Reset state
        tick(3);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.err", 64'(err), 64'd0);
        check("reset.bit_cnt", 64'(bit_cnt), 64'd0);
        check("reset.bus", 64'(singer_bus), 64'd1);
        rst = 1'b0;
        tick(3);

        // Short start: rejected as a glitch
        d0 = done_cnt;
        e0 = err_cnt;
        host_start(30, "short");
        low_hits = 0;
        busy_hits = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (singer_bus !== 1'b1) low_hits++;
            if (busy !== 1'b0) busy_hits++;
        end
        check("short.bus_driven", 64'(low_hits), 64'd0);
        check("short.busy_seen", 64'(busy_hits), 64'd0);
        check("short.done_pulses", 64'(done_cnt - d0), 64'd0);
        check("short.err_pulses", 64'(err_cnt - e0), 64'd0);

        // Nominal frame
        send(40'h3C001A0056, "nominal");
        rx_frame("nominal", 1'b0, '0);
        check("nominal.bit_cnt", 64'(bit_cnt), 64'd40);

        // Loopback with all ones
        tick(20);
        send(40'hFFFFFFFFFF, "loop");
        rx_frame("loop", 1'b0, '0);
        check("loop.bit_cnt", 64'(bit_cnt), 64'd40);

        // data_in changed after acceptance has no effect
        tick(20);
        send(40'hC33C5AA50F, "dchg");
        rx_frame("dchg", 1'b1, 40'h0000000000);

        // Collision during bit 5's high phase
        tick(20);
        data_in = 40'hA50FC3963C;
        d0 = done_cnt;
        e0 = err_cnt;
        host_start(3 * START_C, "coll");
        wait_bitcnt(6'd5, "coll");
        wait_level(1'b1, n);
        tick(11);
        host_low = 1'b1;
        err_at = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (err === 1'b1 && err_at < 0) err_at = k;
        end
        host_low = 1'b0;
        check("coll.err_latency", 64'(err_at), 64'd6);
        check("coll.busy", 64'(busy), 64'd0);
        tick(1);
        run_len(1'b1, 200, n);
        check("coll.bus_released", 64'(n), 64'd200);
        check("coll.err_pulses", 64'(err_cnt - e0), 64'd1);
        check("coll.done_pulses", 64'(done_cnt - d0), 64'd0);

        // Reset during bit 20's low preamble
        data_in = 40'h0123456789;
        d0 = done_cnt;
        e0 = err_cnt;
        host_start(3 * START_C, "rstmid");
        wait_bitcnt(6'd20, "rstmid");
        tick(5);
        check("rstmid.bus_before", 64'(singer_bus), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("rstmid.bus", 64'(singer_bus), 64'd1);
        check("rstmid.busy", 64'(busy), 64'd0);
        check("rstmid.done", 64'(done), 64'd0);
        check("rstmid.err", 64'(err), 64'd0);
        check("rstmid.bit_cnt", 64'(bit_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(5);
        check("rstmid.done_pulses", 64'(done_cnt - d0), 64'd0);
        check("rstmid.err_pulses", 64'(err_cnt - e0), 64'd0);

        // A valid start after reset yields a complete frame
        send(40'h5A96E1D2C7, "refr");
        rx_frame("refr", 1'b0, '0);
        check("refr.bit_cnt", 64'(bit_cnt), 64'd40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dht_sensor_responder.md
# dht_sensor_responder

Single-wire temperature/humidity sensor responder. It is the slave end of the `singer_bus` protocol driven by our FPGA sensor reader, and serves as an on-FPGA sensor emulator and loopback target for reader bring-up and regression. It detects a host start pulse, answers with the 80/80 µs presence handshake, and then transmits an N-bit frame MSB-first using pulse-width encoding. The bus is open-drain: the block only ever drives 0 or releases to Z, and an external or modelled pull-up supplies the high level.

## Interface
- `CLK_PERIOD_NS`, 83: clock period (12 MHz). Every delay is converted to cycles as `(ns / CLK_PERIOD_NS) + 1` using integer division.
- `N`, 40: frame length in bits.
- `START_MIN_NS`, 500000: minimum host low time accepted as a start (6025 cycles).
- `RESP_WAIT_NS`, 30000: wait after the host releases, before the response (362 cycles).
- `RESP_NS`, 80000: response low time and response high time (964 cycles each).
- `BIT_LOW_NS`, 50000: per-bit low preamble and end low (603 cycles).
- `BIT0_HIGH_NS`, 26000: high time for a 0 bit (314 cycles).
- `BIT1_HIGH_NS`, 70000: high time for a 1 bit (844 cycles).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, **asynchronous, active-high**.
- `singer_bus` inout 1: open-drain sensor line.
- `data_in` in N: frame to send; the checksum byte is supplied by the user.
- `busy` out 1: high from start acceptance until the bus is released.
- `done` out 1: one-cycle pulse when a frame completes.
- `err` out 1: one-cycle pulse on collision abort.
- `bit_cnt` out 6: number of bits sent in the current frame.

## Operation
**Input conditioning**
- `singer_bus` passes through a 2-flop synchronizer to produce `bus_s`.
- All edge detection uses `bus_s`.

**Bus drive**
- `singer_bus = oe ? 1'b0 : 1'bz`.
- `oe` is registered.

**State machine**
- `IDLE`: bus released. If `bus_s==0`, go to `HOST_LOW` with the counter cleared.
- `HOST_LOW`: count cycles while `bus_s==0`.
  - On `bus_s==1` with count ≥ START_MIN: capture `data_in` into the shift register, set `busy`, go to `RESP_WAIT`.
  - On `bus_s==1` with a shorter count: treat as a glitch and return to `IDLE` with no outputs.
- `RESP_WAIT`: released for RESP_WAIT cycles, then go to `RESP_LOW`.
- `RESP_LOW`: `oe=1` for RESP cycles, then go to `RESP_HIGH`.
- `RESP_HIGH`: released for RESP cycles, then go to `BIT_LOW`.
- `BIT_LOW`: `oe=1` for BIT_LOW cycles, then go to `BIT_HIGH`.
- `BIT_HIGH`: released for BIT1_HIGH cycles if `shreg[N-1]`, otherwise BIT0_HIGH cycles. Then shift left by 1 and increment `bit_cnt`.
  - If `bit_cnt==N`, go to `END_LOW`.
  - Otherwise go to `BIT_LOW`.
- `END_LOW`: `oe=1` for BIT_LOW cycles. Then release, pulse `done`, clear `busy`, go to `IDLE`.

**Collision check**
- Applies in `RESP_HIGH` and `BIT_HIGH`.
- If `bus_s==0` for 4 consecutive cycles, starting from the 8th cycle of the phase (allowing for pull-up rise and synchronizer lag):
  - release the bus,
  - pulse `err`,
  - clear `busy`,
  - go to `IDLE`.
- No `done` pulse on abort.

**Counters and width**
- One 16-bit down-counter serves every timed phase; the phase ends on the cycle the count reaches 0.
- The START_MIN count saturates and does not wrap.

## Timing
- **Reset values:** state `IDLE`, `oe=0` (bus Z), `busy=0`, `done=0`, `err=0`, `bit_cnt=0`, shift register 0.
- **Reset mid-frame:** the bus is released immediately (asynchronous), with no `done` or `err` pulse.
- **Start-to-response latency:** host rising edge + 2 synchronizer cycles + 1 cycle to `RESP_WAIT` + RESP_WAIT cycles, then the bus goes low.
- **Phase accuracy:** each timed phase lasts exactly its cycle count ±0; `oe` changes on the cycle the state changes.
- **`data_in` sampling:** sampled only in the start-accept cycle. Changes during a frame have no effect.
- **Edge cases:**
  - A host low that persists indefinitely keeps the block in `HOST_LOW` with `busy=0`.
  - A new start is ignored while `busy`; the only effect is a collision, if applicable.
- **`bit_cnt`:** increments at the end of each `BIT_HIGH` and is cleared at start acceptance.

## Structure
- Shared package `dht_timing_pkg`:
  - state enum,
  - `ns2cyc(ns, period)` function,
  - the default timing constants.
- The same constants are shared with the reader so both ends agree on timing.
- One sub-module, `bus_sync`: 2-flop synchronizer plus rise/fall strobes.
- The FSM, counter and shift register live in the top module.

## Test plan
- **Nominal frame:** host drives low 18 ms, then releases; `data_in=40'h3C00_1A00_56`.
  - Expected: low 964 cycles, high 964 cycles.
  - Then 40 bits whose high widths decode (314→0, 844→1) to `3C001A0056`.
  - `done` pulses once; `busy` falls on the same cycle.
- **Short start:** host low for 3000 cycles, then released.
  - Expected: bus never driven, `busy` stays 0, no pulses.
- **Loopback with the reader:** our reader instance plus a pull-up model, `data_in=40'hFFFF_FFFF_FF`.
  - Expected: reader `dataout=40'hFFFF_FFFF_FF`; the responder's `bit_cnt` ends at 40.
- **Collision:** the bench forces the bus low for 10 cycles in the middle of bit 5's `BIT_HIGH`.
  - Expected: `err` pulses, bus released, no `done`, back in `IDLE`.
- **Reset mid-frame:** assert `rst` during bit 20's `BIT_LOW`.
  - Expected: bus Z within the same cycle, all outputs at reset values.
  - A following valid start yields a complete frame.
- **`data_in` change mid-frame:** change `data_in` after start acceptance.
  - Expected: the transmitted frame equals the value captured at acceptance.
